boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Boot-time sequencer for the core's single-port program/data block RAM.
- After reset it holds the core in reset and receives a program image byte-stream from the UART receiver. It writes the image into BRAM from word 0, then releases the core.
- While loading it owns the BRAM port. Once the core runs, it passes the core's memory signals through unchanged.
- memdout goes from BRAM straight to the core and does not pass through this block.

Parameters:
- MEM_DEPTH, 256, BRAM depth in 32-bit words; upper bound on word count.
- ADDR_W, 8, BRAM word-address width; must satisfy 2**ADDR_W >= MEM_DEPTH.
- HOLD_CYCLES, 4, clocks core_rstn stays low after the last word is written (core reset is synchronous); legal range 1..255.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- rx_err  in  1  one-cycle pulse: UART framing error.
- core_memwe  in  1  core BRAM write enable.
- core_memaddr  in  ADDR_W  core BRAM word address.
- core_memdin  in  32  core BRAM write data.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM word address.
- mem_din  out  32  BRAM write data.
- core_rstn  out  1  synchronous active-low reset to the core.
- loading  out  1  high in S_LEN0/S_LEN1/S_DATA.
- error  out  1  high in S_ERR.

Behaviour:
- Clock and reset:
  - One clock domain (clk); reset is asynchronous, active-low (rstn).
  - All state and registered outputs clear immediately on rstn low.
- Reset values:
  - State = S_LEN0; wcount = 0; widx = 0; bcnt = 0; word buffer = 0; hold counter = 0.
  - Registered loader outputs: we = 0, addr = 0, din = 0.
  - core_rstn = 0, loading = 1, error = 0.
- Image format:
  - 2-byte little-endian word count N, then 4N bytes.
  - Each word is little-endian (first byte → bits 7:0).
  - Words are written to addresses 0..N-1.
- State machine (rx_valid sampled on rising clk):
  - S_LEN0: on rx_valid, wcount[7:0] <= rx_data; go to S_LEN1.
  - S_LEN1: on rx_valid, form N = {rx_data, wcount[7:0]}.
    - N == 0 or N > MEM_DEPTH → S_ERR.
    - Otherwise wcount <= N, widx <= 0, bcnt <= 0 → S_DATA.
  - S_DATA, rx_valid with bcnt < 3: store byte into buffer lane bcnt; bcnt++.
  - S_DATA, rx_valid with bcnt == 3:
    - Next cycle: loader we = 1, addr = widx, din = {rx_data, buf[23:0]}.
    - bcnt <= 0, widx++.
    - If widx == wcount-1 → S_HOLD with hold counter = HOLD_CYCLES; else stay in S_DATA.
  - Write pulse: loader we is high for exactly one cycle per word and is 0 in every other cycle.
  - S_HOLD: count down each clock; core_rstn stays 0; on reaching 0 → S_RUN.
  - S_RUN: core_rstn = 1; rx_valid and rx_err are ignored; stays until rstn.
  - S_ERR: core_rstn = 0, error = 1, BRAM we = 0; stays until rstn.
- Timing:
  - Final byte sampled at edge E → its write occurs in the cycle after E.
  - core_rstn rises exactly at edge E+1+HOLD_CYCLES and is registered, glitch-free.
- rx_err: in S_LEN0/S_LEN1/S_DATA → S_ERR at the next edge, with no write for a partial word. If rx_err and rx_valid occur in the same cycle, rx_err wins.
- Port mux (combinational select on a registered state bit):
  - S_RUN: mem_we/mem_addr/mem_din = core_memwe/core_memaddr/core_memdin.
  - All other states: loader registers.
  - The core is in reset outside S_RUN, so the mux needs no arbitration.
- Address width: widx is ADDR_W+1 bits internally; mem_addr uses widx[ADDR_W-1:0]. N = MEM_DEPTH writes the top address without wrapping.
- Reset mid-load: all progress is lost; BRAM contents already written are left as-is; the loader restarts at S_LEN0 awaiting a new header.

Test Plan:
- Normal load: bytes 02 00, 13 05 10 00, 73 00 00 00.
  - mem_we pulses at addr 0 with din 0x00100513, then at addr 1 with din 0x00000073.
  - core_rstn rises 5 edges after the last byte; loading = 0; mux then follows core_memaddr = 0x3C, core_memwe = 1.
- Bad length: header 00 00 → error = 1, no mem_we ever. Header 01 01 (257) → error = 1, core_rstn stays 0.
- Framing error: rx_err after 2 data bytes of word 0 → S_ERR, no write, subsequent rx_valid ignored.
- Reset mid-load: after word 0 of a 3-word image, assert rstn low for 1 cycle → all outputs at reset values; a fresh 1-word image (01 00 EF BE AD DE) writes 0xDEADBEEF to addr 0.
- Full depth: N = 256 (00 01) with a counting pattern → 256 writes to addr 0x00..0xFF in order, no wrap, then core release.
- Back-to-back bytes: rx_valid on consecutive cycles across a word boundary → every byte captured, each write exactly one cycle wide.

Source files
------------

// File: rtl/boot_loader.sv
// Boot-time sequencer: receives a length-prefixed program image from the UART,
// writes it into the core's block RAM from word 0, then releases the core.
module boot_loader #(
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  input  logic              core_memwe,
  input  logic [ADDR_W-1:0] core_memaddr,
  input  logic [31:0]       core_memdin,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              core_rstn,
  output logic              loading,
  output logic              error
);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_HOLD = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         wcount_q, wcount_d;
  logic [ADDR_W:0]     widx_q, widx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         buf_q, buf_d;
  logic [7:0]          hold_q, hold_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic                run_q, run_d;

  logic [15:0]         hdr_n;
  logic                last_word;

  assign hdr_n     = {rx_data, wcount_q[7:0]};
  assign last_word = (16'(widx_q) == (wcount_q - 16'd1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_LEN0;
      wcount_q <= '0;
      widx_q   <= '0;
      bcnt_q   <= '0;
      buf_q    <= '0;
      hold_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcount_q <= wcount_d;
      widx_q   <= widx_d;
      bcnt_q   <= bcnt_d;
      buf_q    <= buf_d;
      hold_q   <= hold_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      run_q    <= run_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcount_d = wcount_q;
    widx_d   = widx_q;
    bcnt_d   = bcnt_q;
    buf_d    = buf_q;
    hold_d   = hold_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;

    case (state_q)
      S_LEN0: begin
        if (rx_err) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          wcount_d[7:0] = rx_data;
          state_d       = S_LEN1;
        end
      end
      S_LEN1: begin
        if (rx_err) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          if ((hdr_n == 16'd0) || (hdr_n > 16'(MEM_DEPTH))) begin
            state_d = S_ERR;
          end else begin
            wcount_d = hdr_n;
            widx_d   = '0;
            bcnt_d   = '0;
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_err) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          if (bcnt_q == 2'd3) begin
            // The fourth byte goes straight into the write data, not the buffer.
            we_d   = 1'b1;
            addr_d = widx_q[ADDR_W-1:0];
            din_d  = {rx_data, buf_q};
            bcnt_d = 2'd0;
            widx_d = widx_q + (ADDR_W+1)'(1);
            if (last_word) begin
              hold_d  = 8'(HOLD_CYCLES);
              state_d = S_HOLD;
            end
          end else begin
            case (bcnt_q)
              2'd0:    buf_d[7:0]   = rx_data;
              2'd1:    buf_d[15:8]  = rx_data;
              default: buf_d[23:16] = rx_data;
            endcase
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == 8'd0) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    run_d = (state_d == S_RUN);
  end

  // run_q is a flop, so the core reset and the port select change cleanly together.
  assign core_rstn = run_q;
  assign mem_we    = run_q ? core_memwe   : we_q;
  assign mem_addr  = run_q ? core_memaddr : addr_q;
  assign mem_din   = run_q ? core_memdin  : din_q;
  assign loading   = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
  assign error     = (state_q == S_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and randomized images checked
// against an image-level reference model of the expected BRAM writes.
module tb_boot_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int HOLD  = 4;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_err = 1'b0;
  logic          core_memwe = 1'b0;
  logic [AW-1:0] core_memaddr = '0;
  logic [31:0]   core_memdin = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          core_rstn;
  logic          loading;
  logic          error;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] wr_q[$];
  logic [39:0] exp_q[$];
  bit          exp_err;

  always #5 clk = ~clk;

  boot_loader #(.MEM_DEPTH(DEPTH), .ADDR_W(AW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .core_memwe(core_memwe), .core_memaddr(core_memaddr), .core_memdin(core_memdin),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .core_rstn(core_rstn), .loading(loading), .error(error)
  );

  // Every BRAM write seen while the core is held in reset belongs to the loader.
  always @(negedge clk) begin
    if (rstn === 1'b1 && core_rstn === 1'b0 && mem_we === 1'b1)
      wr_q.push_back({mem_addr, mem_din});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected writes: header gives N, then every complete 4-byte group is word w at address w.
  task automatic model(input bq_t s);
    int n;
    exp_q.delete();
    exp_err = 1'b0;
    if (s.size() < 2) return;
    n = int'({s[1], s[0]});
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n && (2 + 4*w + 3) < s.size(); w++)
      exp_q.push_back({8'(w), s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rstn = 1'b0;
    rx_valid = 1'b0;
    rx_err = 1'b0;
    core_memwe = 1'b1;
    core_memaddr = 8'hA5;
    core_memdin = 32'hFFFF_FFFF;
    #1;
    check({tag, "_rst_we"},      mem_we,    1'b0);
    check({tag, "_rst_addr"},    mem_addr,  '0);
    check({tag, "_rst_din"},     mem_din,   '0);
    check({tag, "_rst_corerst"}, core_rstn, 1'b0);
    check({tag, "_rst_loading"}, loading,   1'b1);
    check({tag, "_rst_error"},   error,     1'b0);
    @(negedge clk);
    rstn = 1'b1;
    wr_q.delete();
  endtask

  task automatic send(input bq_t s, input bit b2b, input int gap_max);
    for (int i = 0; i < s.size(); i++) begin
      if (!b2b && i > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = s[i];
      core_memaddr = 8'($urandom);
      core_memdin = $urandom;
      if (!b2b) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    if (b2b) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic check_writes(input string tag);
    int m;
    check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
    m = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
  endtask

  // Called at the falling edge right after the last byte was sampled.
  task automatic check_release(input string tag);
    check({tag, "_loading_off"}, loading, 1'b0);
    for (int k = 0; k <= HOLD + 1; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s_corerst_e%0d", tag, k), core_rstn, logic'(k == HOLD + 1));
    end
    core_memaddr = 8'h3C;
    core_memwe = 1'b1;
    core_memdin = $urandom;
    #1;
    check({tag, "_mux_addr"}, mem_addr, 8'h3C);
    check({tag, "_mux_we"},   mem_we,   1'b1);
    check({tag, "_mux_din"},  mem_din,  core_memdin);
    core_memwe = 1'b0;
  endtask

  task automatic load_ok(input string tag, input bq_t s, input bit b2b);
    model(s);
    send(s, b2b, 2);
    check_release(tag);
    repeat (2) @(negedge clk);
    check_writes(tag);
    check({tag, "_no_error"}, error, 1'b0);
    $display("%s: image of %0d bytes, %0d words written", tag, s.size(), wr_q.size());
  endtask

  task automatic expect_error(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_error"},   error,     1'b1);
    check({tag, "_loading"}, loading,   1'b0);
    check({tag, "_corerst"}, core_rstn, 1'b0);
    check({tag, "_we"},      mem_we,    1'b0);
    check({tag, "_wr_none"}, wr_q.size(), 0);
    $display("%s: loader in error, %0d writes", tag, wr_q.size());
  endtask

  initial begin
    bq_t s;
    int  n;

    do_reset("init");

    // Reference image, then confirm rx bytes are ignored once the core runs.
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00};
    load_ok("normal", s, 1'b0);
    check("normal_exp_w0", exp_q[0], {8'h00, 32'h0010_0513});
    wr_q.delete();
    s = '{8'h01, 8'h00, 8'h11, 8'h22};
    send(s, 1'b0, 1);
    check("run_ignore_we",   mem_we,      1'b0);
    check("run_ignore_wr",   wr_q.size(), 0);
    check("run_ignore_rstn", core_rstn,   1'b1);

    do_reset("len0");
    s = '{8'h00, 8'h00};
    model(s);
    check("len0_model_err", exp_err, 1'b1);
    send(s, 1'b0, 1);
    expect_error("len0");

    do_reset("len257");
    s = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send(s, 1'b0, 1);
    expect_error("len257");

    do_reset("frame");
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send(s, 1'b0, 1);
    @(negedge clk); rx_err = 1'b1;
    @(negedge clk); rx_err = 1'b0;
    s = '{8'hCC, 8'hDD, 8'h01, 8'h00, 8'h12, 8'h34};
    send(s, 1'b0, 1);
    expect_error("frame");

    // rx_err coinciding with the byte that would complete word 0.
    do_reset("errvalid");
    s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    send(s, 1'b0, 1);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h04; rx_err = 1'b1;
    @(negedge clk); rx_valid = 1'b0; rx_err = 1'b0;
    s = '{8'h05, 8'h06, 8'h07, 8'h08};
    send(s, 1'b0, 1);
    expect_error("errvalid");

    // Reset after the first word of a three-word image, then a fresh image.
    do_reset("midload");
    s = '{8'h03, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h99};
    model(s);
    send(s, 1'b0, 2);
    repeat (2) @(negedge clk);
    check_writes("midload_part");
    check("midload_loading", loading, 1'b1);
    do_reset("midload_rst");
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_ok("midload_fresh", s, 1'b0);
    check("midload_beef", exp_q[0], {8'h00, 32'hDEAD_BEEF});

    for (int t = 0; t < 4; t++) begin
      do_reset($sformatf("rand%0d", t));
      n = $urandom_range(1, 8);
      s = '{8'(n), 8'h00};
      for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom));
      load_ok($sformatf("rand%0d", t), s, 1'(t % 2));
    end

    do_reset("full");
    s = '{8'h00, 8'h01};
    for (int i = 0; i < 4*DEPTH; i++) s.push_back(8'(i));
    load_ok("full", s, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
